// File: rtl/router_pkt_framer.sv
// ============================================================================
// Module      : router_pkt_framer
// Description : Buffers a payload, prepends sa/da/len/crc and bursts the packet
//               into router_dut's byte port once the router is not busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_pkt_framer #(
    parameter int MAX_PAYLOAD = 64,
    parameter int MIN_PAYLOAD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cfg_sa,
    input  logic [7:0] cfg_da,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    input  logic       busy,
    output logic [7:0] dut_inp,
    output logic       inp_valid,
    output logic       pkt_sent,
    output logic       err_short,
    output logic       err_trunc
);

    localparam int              CW    = $clog2(MAX_PAYLOAD + 1);
    localparam int              AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [CW-1:0]   MAX_C = CW'(MAX_PAYLOAD);
    localparam logic [31:0]     MIN_U = 32'(MIN_PAYLOAD);

    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_SEND     = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   crc_q, crc_d;
    logic [7:0]    sa_q, sa_d;
    logic [7:0]    da_q, da_d;
    logic [31:0]   idx_q, idx_d;
    logic          gap_q, gap_d;
    logic [7:0]    dut_inp_q, dut_inp_d;
    logic          inp_valid_q, inp_valid_d;
    logic          pkt_sent_q, pkt_sent_d;
    logic          err_short_q, err_short_d;
    logic          err_trunc_q, err_trunc_d;
    logic [7:0]    mem_q [MAX_PAYLOAD];

    logic          w_accept;
    logic [CW-1:0] w_cnt_inc;
    logic [31:0]   w_len;
    logic [AW-1:0] w_pidx;
    logic [7:0]    w_byte;

    assign pl_ready  = reset && (state_q == S_COLLECT);
    assign w_accept  = pl_valid && pl_ready;
    assign w_cnt_inc = cnt_q + CW'(1);
    assign w_len     = 32'(cnt_q) + 32'd10;
    assign w_pidx    = idx_q[AW-1:0] - AW'(10);

    // Header bytes come from registers; anything past the header is payload.
    always_comb begin
        w_byte = mem_q[w_pidx];
        case (idx_q)
            32'd0:   w_byte = sa_q;
            32'd1:   w_byte = da_q;
            32'd2:   w_byte = w_len[7:0];
            32'd3:   w_byte = w_len[15:8];
            32'd4:   w_byte = w_len[23:16];
            32'd5:   w_byte = w_len[31:24];
            32'd6:   w_byte = crc_q[7:0];
            32'd7:   w_byte = crc_q[15:8];
            32'd8:   w_byte = crc_q[23:16];
            32'd9:   w_byte = crc_q[31:24];
            default: w_byte = mem_q[w_pidx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[cnt_q[AW-1:0]] <= pl_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        sa_d        = sa_q;
        da_d        = da_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        dut_inp_d   = dut_inp_q;
        inp_valid_d = inp_valid_q;
        pkt_sent_d  = 1'b0;
        err_short_d = 1'b0;
        err_trunc_d = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (w_accept) begin
                    cnt_d = w_cnt_inc;
                    crc_d = crc_q + {24'b0, pl_data};
                    if (cnt_q == '0) begin
                        sa_d = cfg_sa;
                        da_d = cfg_da;
                    end
                    if (pl_last || (w_cnt_inc == MAX_C)) begin
                        err_trunc_d = !pl_last;
                        if (32'(w_cnt_inc) < MIN_U) begin
                            err_short_d = 1'b1;
                            cnt_d       = '0;
                            crc_d       = '0;
                        end else begin
                            state_d = S_WAIT_RDY;
                        end
                    end
                end
            end
            S_WAIT_RDY: begin
                if (!busy) begin
                    inp_valid_d = 1'b1;
                    dut_inp_d   = sa_q;
                    idx_d       = 32'd1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q == w_len) begin
                    inp_valid_d = 1'b0;
                    dut_inp_d   = 8'h00;
                    pkt_sent_d  = 1'b1;
                    gap_d       = 1'b0;
                    state_d     = S_GAP;
                end else begin
                    dut_inp_d = w_byte;
                    idx_d     = idx_q + 32'd1;
                end
            end
            S_GAP: begin
                if (gap_q) begin
                    cnt_d   = '0;
                    crc_d   = '0;
                    state_d = S_COLLECT;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_COLLECT;
            cnt_q       <= '0;
            crc_q       <= '0;
            sa_q        <= 8'h00;
            da_q        <= 8'h00;
            idx_q       <= '0;
            gap_q       <= 1'b0;
            dut_inp_q   <= 8'h00;
            inp_valid_q <= 1'b0;
            pkt_sent_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            sa_q        <= sa_d;
            da_q        <= da_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            dut_inp_q   <= dut_inp_d;
            inp_valid_q <= inp_valid_d;
            pkt_sent_q  <= pkt_sent_d;
            err_short_q <= err_short_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    assign dut_inp   = dut_inp_q;
    assign inp_valid = inp_valid_q;
    assign pkt_sent  = pkt_sent_q;
    assign err_short = err_short_q;
    assign err_trunc = err_trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_framer.sv
// ============================================================================
// Module      : tb_router_pkt_framer
// Description : Directed self-checking bench for router_pkt_framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_pkt_framer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cfg_sa = 8'h00;
    logic [7:0] cfg_da = 8'h00;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       pl_last = 1'b0;
    logic       busy = 1'b0;
    logic       pl_ready;
    logic [7:0] dut_inp;
    logic       inp_valid;
    logic       pkt_sent;
    logic       err_short;
    logic       err_trunc;

    int checks = 0;
    int errors = 0;

    logic [7:0] pay  [0:127];
    logic [7:0] expb [0:127];
    logic [7:0] got  [0:255];
    int         exp_n;
    int         got_n;
    int         wait_cyc;
    logic       timeout;
    logic       sent_seen;
    logic       ready_low_ok;
    logic       trunc_seen;
    logic       short_seen;

    always #5 clk = ~clk;

    router_pkt_framer #(
        .MAX_PAYLOAD(64),
        .MIN_PAYLOAD(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_sa   (cfg_sa),
        .cfg_da   (cfg_da),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_last  (pl_last),
        .pl_ready (pl_ready),
        .busy     (busy),
        .dut_inp  (dut_inp),
        .inp_valid(inp_valid),
        .pkt_sent (pkt_sent),
        .err_short(err_short),
        .err_trunc(err_trunc)
    );

    function automatic void build_exp(input logic [7:0] sa, input logic [7:0] da, input int n);
        logic [31:0] s;
        logic [31:0] l;
        s = 32'd0;
        for (int i = 0; i < n; i++) s = s + {24'b0, pay[i]};
        l = 32'(n + 10);
        expb[0] = sa;
        expb[1] = da;
        for (int b = 0; b < 4; b++) begin
            expb[2 + b] = l[8*b +: 8];
            expb[6 + b] = s[8*b +: 8];
        end
        for (int i = 0; i < n; i++) expb[10 + i] = pay[i];
        exp_n = n + 10;
    endfunction

    // Starts and ends just after a falling edge; cfg_* are scrambled after the
    // first byte so late changes must not leak into the header.
    task automatic drive_pkt(input logic [7:0] sa, input logic [7:0] da, input int n,
                             input bit use_last, input bit hold);
        cfg_sa = sa;
        cfg_da = da;
        for (int i = 0; i < n; i++) begin
            pl_valid = 1'b1;
            pl_data  = pay[i];
            pl_last  = use_last && (i == n - 1);
            @(negedge clk);
            if (i == 0) begin
                cfg_sa = ~sa;
                cfg_da = ~da;
            end
        end
        trunc_seen = err_trunc;
        short_seen = err_short;
        if (hold) begin
            pl_valid = 1'b1;
            pl_data  = 8'hAA;
            pl_last  = 1'b1;
        end else begin
            pl_valid = 1'b0;
            pl_last  = 1'b0;
        end
    endtask

    task automatic capture(input int budget);
        got_n        = 0;
        wait_cyc     = 0;
        timeout      = 1'b0;
        sent_seen    = 1'b0;
        ready_low_ok = 1'b1;
        do begin
            @(negedge clk);
            wait_cyc++;
            if (pl_ready) ready_low_ok = 1'b0;
        end while (!inp_valid && wait_cyc < budget);
        if (!inp_valid) begin
            timeout = 1'b1;
        end else begin
            while (inp_valid && got_n < 250) begin
                got[got_n] = dut_inp;
                got_n++;
                if (pl_ready) ready_low_ok = 1'b0;
                @(negedge clk);
            end
            sent_seen = pkt_sent;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({dut_inp, inp_valid, pkt_sent, err_short, err_trunc} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {dut_inp, inp_valid, pkt_sent, err_short, err_trunc});
        end
        checks++;
        if (pl_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pl_ready: got %b expected 0", pl_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_pl_ready: got %b expected 1", pl_ready);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
        build_exp(8'h04, 8'h08, 10);
        drive_pkt(8'h04, 8'h08, 10, 1'b1, 1'b0);
        checks++;
        if (trunc_seen !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_trunc: got %b expected 0", trunc_seen);
        end
        capture(10);
        checks++;
        if (timeout !== 1'b0 || wait_cyc !== 1) begin
            errors++;
            $display("FAIL basic_start_latency: got %0d cycles (timeout %b) expected 1", wait_cyc, timeout);
        end
        checks++;
        if (got_n !== 20) begin
            errors++;
            $display("FAIL basic_burst_len: got %0d expected 20", got_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL basic_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        checks++;
        if (got[2] !== 8'h14 || got[6] !== 8'h37) begin
            errors++;
            $display("FAIL basic_len_crc: got %h/%h expected 14/37", got[2], got[6]);
        end
        checks++;
        if (sent_seen !== 1'b1) begin
            errors++;
            $display("FAIL basic_pkt_sent: got %b expected 1", sent_seen);
        end
        @(negedge clk);
        checks++;
        if (pkt_sent !== 1'b0 || pl_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap2: got pkt_sent %b pl_ready %b expected 0 0", pkt_sent, pl_ready);
        end
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_return: got %b expected 1", pl_ready);
        end
    endtask

    task automatic test_busy();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) pay[i] = 8'(8'h10 + i);
        build_exp(8'h21, 8'h42, 5);
        busy = 1'b1;
        drive_pkt(8'h21, 8'h42, 5, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (inp_valid !== 1'b0 || pl_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold: got activity while busy=1 expected none");
        end
        busy = 1'b0;
        capture(5);
        checks++;
        if (timeout !== 1'b0 || wait_cyc !== 1 || got[0] !== 8'h21) begin
            errors++;
            $display("FAIL busy_release: got %0d cycles first %h expected 1 cycle 21", wait_cyc, got[0]);
        end
        checks++;
        if (got_n !== exp_n) begin
            errors++;
            $display("FAIL busy_burst_len: got %0d expected %0d", got_n, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL busy_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        checks++;
        if (ready_low_ok !== 1'b1 || sent_seen !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready_sent: got %b %b expected 1 1", ready_low_ok, sent_seen);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_crc_width();
        for (int i = 0; i < 20; i++) pay[i] = 8'hFF;
        build_exp(8'h01, 8'h02, 20);
        drive_pkt(8'h01, 8'h02, 20, 1'b1, 1'b0);
        capture(10);
        checks++;
        if (got_n !== 30) begin
            errors++;
            $display("FAIL crc_burst_len: got %0d expected 30", got_n);
        end
        checks++;
        if ({got[2], got[6], got[7], got[8], got[9]} !== 40'h1E_EC_13_00_00) begin
            errors++;
            $display("FAIL crc_width: got %h %h %h %h %h expected 1e ec 13 00 00",
                     got[2], got[6], got[7], got[8], got[9]);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL crc_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_short();
        logic bad;
        bad = 1'b0;
        pay[0] = 8'h5A;
        drive_pkt(8'h0C, 8'h0D, 1, 1'b1, 1'b0);
        checks++;
        if (short_seen !== 1'b1 || pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_drop: got err_short %b pl_ready %b expected 1 1", short_seen, pl_ready);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (inp_valid !== 1'b0 || err_short !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL short_quiet: got output activity expected none");
        end
        for (int i = 0; i < 3; i++) pay[i] = 8'(8'hA0 + i);
        build_exp(8'h0E, 8'h0F, 3);
        drive_pkt(8'h0E, 8'h0F, 3, 1'b1, 1'b0);
        capture(10);
        checks++;
        if (got_n !== 13 || got[2] !== 8'h0D || got[6] !== 8'hE3 || got[7] !== 8'h01) begin
            errors++;
            $display("FAIL short_next_pkt: got n=%0d len %h crc %h%h expected 13 0d 01e3",
                     got_n, got[2], got[7], got[6]);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL short_next_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        build_exp(8'h55, 8'h66, 64);
        drive_pkt(8'h55, 8'h66, 64, 1'b0, 1'b1);
        checks++;
        if (trunc_seen !== 1'b1) begin
            errors++;
            $display("FAIL trunc_flag: got %b expected 1", trunc_seen);
        end
        capture(10);
        checks++;
        if (got_n !== 74 || got[2] !== 8'h4A || got[6] !== 8'hE0 || got[7] !== 8'h07) begin
            errors++;
            $display("FAIL trunc_header: got n=%0d len %h crc %h%h expected 74 4a 07e0",
                     got_n, got[2], got[7], got[6]);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL trunc_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        checks++;
        if (ready_low_ok !== 1'b1 || sent_seen !== 1'b1) begin
            errors++;
            $display("FAIL trunc_ready_sent: got %b %b expected 1 1", ready_low_ok, sent_seen);
        end
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b0) begin
            errors++;
            $display("FAIL trunc_gap_ready: got %b expected 0", pl_ready);
        end
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL trunc_ready_return: got %b expected 1", pl_ready);
        end
        // The held byte (with pl_last) is accepted only now, as a 1-byte runt.
        @(negedge clk);
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        checks++;
        if (err_short !== 1'b1) begin
            errors++;
            $display("FAIL trunc_held_byte: got err_short %b expected 1", err_short);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'h30 + i);
        drive_pkt(8'h11, 8'h22, 10, 1'b1, 1'b0);
        for (int k = 0; k < 20 && !inp_valid; k++) @(negedge clk);
        checks++;
        if (inp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start: got inp_valid %b expected 1", inp_valid);
        end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (inp_valid !== 1'b0 || dut_inp !== 8'h00 || pl_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got valid %b data %h ready %b expected 0 00 0",
                     inp_valid, dut_inp, pl_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: got %b expected 1", pl_ready);
        end
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'h50 + i);
        build_exp(8'h33, 8'h44, 10);
        drive_pkt(8'h33, 8'h44, 10, 1'b1, 1'b0);
        capture(10);
        checks++;
        if (got_n !== 20 || got[2] !== 8'h14 || got[6] !== 8'h4D || got[7] !== 8'h03) begin
            errors++;
            $display("FAIL rstmid_fresh: got n=%0d len %h crc %h%h expected 20 14 034d",
                     got_n, got[2], got[7], got[6]);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (got[i] !== expb[i]) begin
                errors++;
                $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, got[i], expb[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_crc_width();
        test_short();
        test_trunc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
